// File: rtl/brick_map_writer_pkg.sv
// rtl/brick_map_writer_pkg.sv - shared constants, types and helpers for the brick map writer
// Purpose: map geometry, field limits, FSM state encoding and the queued hit cell type.
// Ports: none (package).
package brick_map_pkg;

    localparam int ROWS       = 15;
    localparam int COLS       = 20;
    localparam int CELL_SHIFT = 5;
    localparam int X_LIMIT    = 543;
    localparam int Y_LIMIT    = 479;

    typedef enum logic [1:0] {
        LOAD,
        COUNT,
        RUN,
        APPLY
    } state_t;

    typedef struct packed {
        logic [3:0] row;
        logic [4:0] col;
    } cell_t;

    function automatic logic [8:0] popcount_row(input logic [COLS-1:0] bits);
        logic [8:0] n;
        n = '0;
        for (int i = 0; i < COLS; i++) begin
            n = n + 9'(bits[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/brick_map_writer_hit_fifo.sv
// rtl/brick_map_writer_hit_fifo.sv - pending-hit queue of map cells
// Purpose: synchronous FIFO of cell_t entries; reset flushes all entries.
// Ports: clk_i, reset_i (async active-high); push_i/data_i write side;
//        pop_i/data_o read side (data_o shows the head entry); full_o, empty_o, count_o.
module hit_fifo
    import brick_map_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          push_i,
    input  cell_t         data_i,
    input  logic          pop_i,
    output cell_t         data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    cell_t         mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_q];

    // Writes into a full queue and reads from an empty one are dropped.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + AW'(1);
            end
            if (do_pop) begin
                rd_q <= (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/brick_map_writer.sv
// rtl/brick_map_writer.sv - live strong-brick occupancy map with frame-synchronous hit clearing
// Purpose: loads one of four initial maps after reset, counts bricks, queues hits from the
//          collision logic and clears them only after start_of_frame.
// Ports: clk, reset (async active-high); random selects mat0..mat3 at load;
//        start_of_frame pulse; hit_valid/hit_x/hit_y/hit_ready hit handshake;
//        map_out, bricks_left, load_done, all_cleared toward the brick drawer.
module brick_map_writer #(
    parameter int ROWS       = brick_map_pkg::ROWS,
    parameter int COLS       = brick_map_pkg::COLS,
    parameter int CELL_SHIFT = brick_map_pkg::CELL_SHIFT,
    parameter int X_LIMIT    = brick_map_pkg::X_LIMIT,
    parameter int Y_LIMIT    = brick_map_pkg::Y_LIMIT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [1:0]                   random,
    input  logic [0:ROWS-1][0:COLS-1]    mat0,
    input  logic [0:ROWS-1][0:COLS-1]    mat1,
    input  logic [0:ROWS-1][0:COLS-1]    mat2,
    input  logic [0:ROWS-1][0:COLS-1]    mat3,
    input  logic                         start_of_frame,
    input  logic                         hit_valid,
    input  logic [10:0]                  hit_x,
    input  logic [10:0]                  hit_y,
    output logic                         hit_ready,
    output logic [0:ROWS-1][0:COLS-1]    map_out,
    output logic [8:0]                   bricks_left,
    output logic                         load_done,
    output logic                         all_cleared
);
    import brick_map_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    state_t                      state_q, state_d;
    logic [0:ROWS-1][0:COLS-1]   map_q, map_d;
    logic [8:0]                  bricks_q, bricks_d;
    logic                        load_done_q, load_done_d;
    logic                        all_cleared_q, all_cleared_d;
    logic [3:0]                  row_q, row_d;

    cell_t                       push_cell, head_cell;
    logic                        in_field, push, pop, full, empty;
    logic [CW-1:0]               count;

    // Zero coordinates mean "no real position" on the collision side, so they are discarded too.
    assign in_field = (hit_x != '0) && (hit_y != '0) &&
                      (hit_x < 11'(X_LIMIT)) && (hit_y < 11'(Y_LIMIT));

    assign hit_ready     = load_done_q && !full;
    assign push          = hit_valid && hit_ready && in_field;
    assign push_cell.row = 4'(hit_y >> CELL_SHIFT);
    assign push_cell.col = 5'(hit_x >> CELL_SHIFT);

    hit_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_hit_fifo (
        .clk_i   (clk),
        .reset_i (reset),
        .push_i  (push),
        .data_i  (push_cell),
        .pop_i   (pop),
        .data_o  (head_cell),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    always_comb begin
        state_d     = state_q;
        map_d       = map_q;
        bricks_d    = bricks_q;
        load_done_d = load_done_q;
        row_d       = row_q;
        pop         = 1'b0;
        case (state_q)
            LOAD: begin
                case (random)
                    2'd0:    map_d = mat0;
                    2'd1:    map_d = mat1;
                    2'd2:    map_d = mat2;
                    default: map_d = mat3;
                endcase
                bricks_d = '0;
                row_d    = '0;
                state_d  = COUNT;
            end
            COUNT: begin
                bricks_d = bricks_q + popcount_row(map_q[row_q]);
                if (row_q == 4'(ROWS - 1)) begin
                    load_done_d = 1'b1;
                    state_d     = RUN;
                end else begin
                    row_d = row_q + 4'd1;
                end
            end
            RUN: begin
                if (start_of_frame && !empty) begin
                    state_d = APPLY;
                end
            end
            APPLY: begin
                if (empty) begin
                    state_d = RUN;
                end else begin
                    pop = 1'b1;
                    // Only a 1->0 transition decrements, so duplicate hits cannot underflow.
                    if (map_q[head_cell.row][head_cell.col]) begin
                        map_d[head_cell.row][head_cell.col] = 1'b0;
                        bricks_d = bricks_q - 9'd1;
                    end
                    // A same-cycle push keeps the queue non-empty and extends this APPLY run.
                    if ((count == CW'(1)) && !push) begin
                        state_d = RUN;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
        all_cleared_d = load_done_d && (bricks_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= LOAD;
            map_q         <= '0;
            bricks_q      <= '0;
            load_done_q   <= 1'b0;
            all_cleared_q <= 1'b0;
            row_q         <= '0;
        end else begin
            state_q       <= state_d;
            map_q         <= map_d;
            bricks_q      <= bricks_d;
            load_done_q   <= load_done_d;
            all_cleared_q <= all_cleared_d;
            row_q         <= row_d;
        end
    end

    assign map_out     = map_q;
    assign bricks_left = bricks_q;
    assign load_done   = load_done_q;
    assign all_cleared = all_cleared_q;

endmodule

// File: tb/tb_brick_map_writer.sv
// tb/tb_brick_map_writer.sv - directed self-checking bench for brick_map_writer
module tb_brick_map_writer;

    logic                clk;
    logic                reset;
    logic [1:0]          random;
    logic [0:14][0:19]   mat0, mat1, mat2, mat3;
    logic                sof;
    logic                hit_valid;
    logic [10:0]         hit_x, hit_y;
    logic                hit_ready;
    logic [0:14][0:19]   map_out;
    logic [8:0]          bricks_left;
    logic                load_done;
    logic                all_cleared;

    logic [0:14][0:19]   exp_map;
    int                  vectors;
    int                  miscompares;

    brick_map_writer dut (
        .clk            (clk),
        .reset          (reset),
        .random         (random),
        .mat0           (mat0),
        .mat1           (mat1),
        .mat2           (mat2),
        .mat3           (mat3),
        .start_of_frame (sof),
        .hit_valid      (hit_valid),
        .hit_x          (hit_x),
        .hit_y          (hit_y),
        .hit_ready      (hit_ready),
        .map_out        (map_out),
        .bricks_left    (bricks_left),
        .load_done      (load_done),
        .all_cleared    (all_cleared)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [299:0] obs, input logic [299:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic send_hit(input int x, input int y);
        hit_x     = 11'(x);
        hit_y     = 11'(y);
        hit_valid = 1'b1;
        @(negedge clk);
        hit_valid = 1'b0;
    endtask

    task automatic frame();
        sof = 1'b1;
        @(negedge clk);
        sof = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        random      = 2'd2;
        sof         = 1'b0;
        hit_valid   = 1'b0;
        hit_x       = '0;
        hit_y       = '0;
        mat1        = '0;
        mat1[0][0]  = 1'b1;
        mat2        = '1;
        for (int r = 0; r < 15; r++) begin
            for (int c = 0; c < 20; c++) begin
                mat0[r][c] = (c < 10);
                mat3[r][c] = c[0];
            end
        end

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_map", 300'(map_out), 300'(0));
        chk("rst_bricks", 300'(bricks_left), 300'(0));
        chk("rst_load_done", 300'(load_done), 300'(0));
        chk("rst_all_cleared", 300'(all_cleared), 300'(0));
        chk("rst_hit_ready", 300'(hit_ready), 300'(0));

        // Load mat2 (all ones): 15 edges in, 14 rows counted, not done yet
        reset = 1'b0;
        repeat (15) @(negedge clk);
        chk("count_partial_bricks", 300'(bricks_left), 300'(280));
        chk("count_partial_done", 300'(load_done), 300'(0));
        chk("count_partial_ready", 300'(hit_ready), 300'(0));
        @(negedge clk);
        exp_map = '1;
        chk("load_map", 300'(map_out), 300'(exp_map));
        chk("load_bricks", 300'(bricks_left), 300'(300));
        chk("load_done", 300'(load_done), 300'(1));
        chk("load_ready", 300'(hit_ready), 300'(1));
        chk("load_all_cleared", 300'(all_cleared), 300'(0));

        // Single hit (100,70) -> cell [2][3]
        send_hit(100, 70);
        chk("hit1_before_frame", 300'(bricks_left), 300'(300));
        frame();
        chk("hit1_one_cycle", 300'(bricks_left), 300'(300));
        @(negedge clk);
        exp_map[2][3] = 1'b0;
        chk("hit1_bricks", 300'(bricks_left), 300'(299));
        chk("hit1_map", 300'(map_out), 300'(exp_map));

        // Duplicate hits on [3][6] plus an out-of-field hit
        send_hit(200, 100);
        send_hit(200, 100);
        send_hit(600, 10);
        chk("dup_ready", 300'(hit_ready), 300'(1));
        frame();
        @(negedge clk);
        exp_map[3][6] = 1'b0;
        chk("dup_first_pop", 300'(bricks_left), 300'(298));
        @(negedge clk);
        chk("dup_bricks", 300'(bricks_left), 300'(298));
        chk("dup_map", 300'(map_out), 300'(exp_map));

        // Five back-to-back hits: only four fit in the queue
        hit_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: begin hit_x = 11'd40;  hit_y = 11'd40;  end
                1: begin hit_x = 11'd70;  hit_y = 11'd40;  end
                2: begin hit_x = 11'd130; hit_y = 11'd40;  end
                3: begin hit_x = 11'd542; hit_y = 11'd478; end
                default: begin hit_x = 11'd200; hit_y = 11'd200; end
            endcase
            chk($sformatf("burst_ready_%0d", i), 300'(hit_ready), 300'(i < 4));
            @(negedge clk);
        end
        hit_valid = 1'b0;
        chk("burst_full_hold", 300'(hit_ready), 300'(0));
        frame();
        chk("burst_apply_full", 300'(hit_ready), 300'(0));
        @(negedge clk);
        chk("burst_pop1", 300'(bricks_left), 300'(297));
        repeat (3) @(negedge clk);
        exp_map[1][1]   = 1'b0;
        exp_map[1][2]   = 1'b0;
        exp_map[1][4]   = 1'b0;
        exp_map[14][16] = 1'b0;
        chk("burst_bricks", 300'(bricks_left), 300'(294));
        chk("burst_map", 300'(map_out), 300'(exp_map));
        chk("burst_ready_after", 300'(hit_ready), 300'(1));

        // Reset during APPLY with three hits queued
        send_hit(240, 240);
        send_hit(270, 270);
        send_hit(300, 300);
        frame();
        random = 2'd1;
        #2 reset = 1'b1;
        #1;
        chk("midrst_map", 300'(map_out), 300'(0));
        chk("midrst_bricks", 300'(bricks_left), 300'(0));
        chk("midrst_load_done", 300'(load_done), 300'(0));
        chk("midrst_ready", 300'(hit_ready), 300'(0));
        chk("midrst_all_cleared", 300'(all_cleared), 300'(0));
        @(negedge clk);
        reset = 1'b0;
        repeat (16) @(negedge clk);
        chk("reload_map", 300'(map_out), 300'(mat1));
        chk("reload_bricks", 300'(bricks_left), 300'(1));
        chk("reload_done", 300'(load_done), 300'(1));
        frame();
        repeat (3) @(negedge clk);
        chk("reload_no_stale", 300'(map_out), 300'(mat1));

        // Field boundary discards: x=0, y=0, x=X_LIMIT, y=Y_LIMIT
        send_hit(0, 10);
        send_hit(10, 0);
        send_hit(543, 10);
        send_hit(10, 479);
        frame();
        repeat (2) @(negedge clk);
        chk("edge_discard_bricks", 300'(bricks_left), 300'(1));
        chk("edge_discard_map", 300'(map_out), 300'(mat1));

        // Clear the last brick
        send_hit(10, 10);
        frame();
        chk("last_before_bricks", 300'(bricks_left), 300'(1));
        chk("last_before_cleared", 300'(all_cleared), 300'(0));
        @(negedge clk);
        chk("last_bricks", 300'(bricks_left), 300'(0));
        chk("last_all_cleared", 300'(all_cleared), 300'(1));
        chk("last_map", 300'(map_out), 300'(0));
        send_hit(10, 10);
        frame();
        repeat (2) @(negedge clk);
        chk("post_clear_bricks", 300'(bricks_left), 300'(0));
        chk("post_clear_all_cleared", 300'(all_cleared), 300'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
